// File: rtl/i2c_sht_target.sv
// I2C target modelling the SHT40 side of the bus: address match, command writes,
// and a latched multi-byte measurement frame served on reads. SDA is open-drain.
module i2c_sht_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h44,
  parameter int         READ_BYTES  = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    scl_in,
  input  logic                    sda_in,
  output logic                    sda_pull_low,
  input  logic [8*READ_BYTES-1:0] meas_data,
  output logic                    meas_load,
  output logic [7:0]              cmd_byte,
  output logic                    cmd_valid,
  output logic                    busy,
  output logic [2:0]              state_out
);
  localparam logic [2:0] S_IDLE = 3'd0, S_ADDR = 3'd1, S_ADDR_ACK = 3'd2,
                         S_WR = 3'd3, S_WR_ACK = 3'd4, S_RD = 3'd5, S_RD_ACK = 3'd6;
  localparam int IW = $clog2(READ_BYTES + 1);

  logic [2:0]              state;
  logic                    scl_s1, scl_s2, scl_h, sda_s1, sda_s2, sda_h;
  logic [3:0]              bit_cnt;
  logic [7:0]              shreg, cur_byte;
  logic [IW-1:0]           idx;
  logic                    acked;
  logic [8*READ_BYTES-1:0] frame;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {scl_s1, scl_s2, scl_h} <= 3'b111;
      {sda_s1, sda_s2, sda_h} <= 3'b111;
    end else begin
      {scl_s1, scl_s2, scl_h} <= {scl_in, scl_s1, scl_s2};
      {sda_s1, sda_s2, sda_h} <= {sda_in, sda_s1, sda_s2};
    end
  end

  wire scl_rise = scl_s2 & ~scl_h;
  wire scl_fall = ~scl_s2 & scl_h;
  wire start    = scl_s2 & sda_h & ~sda_s2;
  wire stop     = scl_s2 & ~sda_h & sda_s2;

  // Bytes past the end of the frame read as 0xFF (SDA released)
  always_comb begin
    cur_byte = 8'hFF;
    for (int i = 0; i < READ_BYTES; i++)
      if (idx == IW'(i)) cur_byte = frame[8*(READ_BYTES-1-i) +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      sda_pull_low <= 1'b0;
      meas_load    <= 1'b0;
      cmd_byte     <= 8'h00;
      cmd_valid    <= 1'b0;
      bit_cnt      <= '0;
      shreg        <= '0;
      idx          <= '0;
      acked        <= 1'b0;
      frame        <= '0;
    end else begin
      meas_load <= 1'b0;
      cmd_valid <= 1'b0;
      if (start) begin
        state        <= S_ADDR;
        bit_cnt      <= '0;
        acked        <= 1'b0;
        sda_pull_low <= 1'b0;
      end else if (stop) begin
        state        <= S_IDLE;
        sda_pull_low <= 1'b0;
      end else begin
        case (state)
          S_ADDR: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shreg   <= {shreg[6:0], sda_s2};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              if (shreg[7:1] == TARGET_ADDR) begin
                sda_pull_low <= 1'b1;
                state        <= S_ADDR_ACK;
              end else begin
                state <= S_IDLE;
              end
            end
          end
          S_ADDR_ACK: if (scl_fall) begin
            bit_cnt <= '0;
            if (!shreg[0]) begin
              sda_pull_low <= 1'b0;
              state        <= S_WR;
            end else begin
              frame        <= meas_data;
              meas_load    <= 1'b1;
              idx          <= '0;
              sda_pull_low <= ~meas_data[8*READ_BYTES-1];
              bit_cnt      <= 4'd1;
              state        <= S_RD;
            end
          end
          S_WR: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shreg   <= {shreg[6:0], sda_s2};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                cmd_byte  <= {shreg[6:0], sda_s2};
                cmd_valid <= 1'b1;
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              sda_pull_low <= 1'b1;
              state        <= S_WR_ACK;
            end
          end
          S_WR_ACK: if (scl_fall) begin
            sda_pull_low <= 1'b0;
            bit_cnt      <= '0;
            state        <= S_WR;
          end
          // bit_cnt counts bits already presented in the current byte
          S_RD: if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_pull_low <= 1'b0;
              acked        <= 1'b0;
              state        <= S_RD_ACK;
            end else begin
              sda_pull_low <= ~cur_byte[3'd7 - bit_cnt[2:0]];
              bit_cnt      <= bit_cnt + 4'd1;
            end
          end
          S_RD_ACK: begin
            if (scl_rise) begin
              if (!sda_s2) begin
                acked <= 1'b1;
                if (idx < IW'(READ_BYTES)) idx <= idx + IW'(1);
              end else begin
                sda_pull_low <= 1'b0;
                state        <= S_IDLE;
              end
            end else if (scl_fall && acked) begin
              sda_pull_low <= ~cur_byte[7];
              bit_cnt      <= 4'd1;
              state        <= S_RD;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign state_out = state;
endmodule

// File: tb/tb_i2c_sht_target.sv
// Bench for i2c_sht_target: bit-banged I2C master with a wired-AND SDA and a
// scoreboard queue of expected bus/command bytes.
module tb_i2c_sht_target;
  localparam int H = 20;
  logic        clk = 0, rst_n = 0, scl = 1, sda_m = 1;
  logic        sda, sda_pull_low, meas_load, cmd_valid, busy;
  logic [47:0] meas_data = '0;
  logic [7:0]  cmd_byte;
  logic [2:0]  state_out;
  int checks = 0, failures = 0;
  int n_cmd = 0, n_load = 0, n_pull = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_cmd[$];

  i2c_sht_target dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda), .sda_pull_low(sda_pull_low),
    .meas_data(meas_data), .meas_load(meas_load), .cmd_byte(cmd_byte),
    .cmd_valid(cmd_valid), .busy(busy), .state_out(state_out));

  assign sda = sda_m & ~sda_pull_low;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cmd_valid) begin n_cmd++; got_cmd.push_back(cmd_byte); end
    if (meas_load) n_load++;
    if (sda_pull_low) n_pull++;
  end

  task automatic wclk(input int n); repeat (n) @(posedge clk); #1; endtask
  task automatic i2c_start; sda_m = 1; wclk(5); scl = 1; wclk(H); sda_m = 0; wclk(H); scl = 0; wclk(5); endtask
  task automatic i2c_stop; sda_m = 0; wclk(H); scl = 1; wclk(H); sda_m = 1; wclk(H); endtask
  task automatic put_bit(input logic b, output logic s);
    sda_m = b; wclk(H); scl = 1; wclk(H/2); s = sda; wclk(H/2); scl = 0; wclk(5);
  endtask
  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) put_bit(b[i], s);
    put_bit(1'b1, ack);
  endtask
  task automatic read_byte(input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin put_bit(1'b1, s); b[i] = s; end
    put_bit(nack, s);
  endtask

  task automatic test_reset;
    rst_n = 0; wclk(3);
    checks++; if (sda_pull_low !== 1'b0) begin failures++; $display("FAIL reset_sda got=%b exp=0", sda_pull_low); end
    checks++; if (busy !== 1'b0 || state_out !== 3'd0) begin failures++; $display("FAIL reset_state got busy=%b st=%0d exp 0/0", busy, state_out); end
    checks++; if (cmd_byte !== 8'h00 || cmd_valid !== 1'b0 || meas_load !== 1'b0) begin failures++; $display("FAIL reset_outs got cmd=%h cv=%b ml=%b exp 00/0/0", cmd_byte, cmd_valid, meas_load); end
    rst_n = 1; wclk(5);
  endtask

  task automatic test_write;
    logic a0, a1; logic [7:0] g; int c0;
    c0 = n_cmd;
    i2c_start();
    write_byte(8'h88, a0);
    exp_q.push_back(8'hFD);
    write_byte(8'hFD, a1);
    i2c_stop();
    checks++; if (a0 !== 1'b0 || a1 !== 1'b0) begin failures++; $display("FAIL write_acks got %b%b exp 00", a0, a1); end
    checks++; if (n_cmd - c0 != 1) begin failures++; $display("FAIL write_cmd_pulses got=%0d exp=1", n_cmd - c0); end
    g = got_cmd.size() ? got_cmd.pop_front() : 8'hxx;
    checks++; if (g !== exp_q.pop_front()) begin failures++; $display("FAIL write_cmd_byte got=%h exp=fd", g); end
    checks++; if (busy !== 1'b0 || cmd_byte !== 8'hFD) begin failures++; $display("FAIL write_after_stop got busy=%b cmd=%h exp 0/fd", busy, cmd_byte); end
  endtask

  task automatic test_addr_mismatch;
    logic a0, a1; int c0, p0;
    c0 = n_cmd; p0 = n_pull;
    i2c_start();
    write_byte(8'h8A, a0);
    checks++; if (a0 !== 1'b1 || state_out !== 3'd0) begin failures++; $display("FAIL mismatch_nack got ack=%b st=%0d exp 1/0", a0, state_out); end
    write_byte(8'hFD, a1);
    checks++; if (state_out !== 3'd0 || n_pull != p0) begin failures++; $display("FAIL mismatch_idle got st=%0d pulls=%0d exp 0/0", state_out, n_pull - p0); end
    checks++; if (n_cmd != c0) begin failures++; $display("FAIL mismatch_cmd got=%0d exp=0", n_cmd - c0); end
    i2c_stop();
  endtask

  // Read n bytes, ACK all but the last; expected bytes come from exp_q
  task automatic do_read(input string nm, input int n);
    logic [7:0] b, e;
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, b);
      if (i == 0) meas_data = ~meas_data;  // must not affect latched frame
      e = exp_q.pop_front();
      checks++; if (b !== e) begin failures++; $display("FAIL %s_byte%0d got=%h exp=%h", nm, i, b, e); end
    end
    checks++; if (sda_pull_low !== 1'b0 || state_out !== 3'd0) begin failures++; $display("FAIL %s_nack got sda=%b st=%0d exp 0/0", nm, sda_pull_low, state_out); end
  endtask

  task automatic test_read;
    logic a; int l0;
    meas_data = 48'h6666_93_8000_A2; l0 = n_load;
    foreach (meas_data[i]) if (i % 8 == 7) exp_q.push_back(meas_data[i -: 8]);
    i2c_start();
    write_byte(8'h89, a);
    checks++; if (a !== 1'b0 || n_load - l0 != 1) begin failures++; $display("FAIL read_addr got ack=%b loads=%0d exp 0/1", a, n_load - l0); end
    do_read("read", 6);
    i2c_stop();
  endtask

  task automatic test_repeated_start;
    logic a0, a1, a2; int l0; logic [7:0] g;
    meas_data = 48'hA5C3_1E_F00F_5A;
    i2c_start();
    write_byte(8'h88, a0); write_byte(8'hFD, a1);
    g = got_cmd.size() ? got_cmd.pop_front() : 8'hxx;
    checks++; if (g !== 8'hFD) begin failures++; $display("FAIL rs_cmd got=%h exp=fd", g); end
    l0 = n_load;
    exp_q.push_back(8'hA5); exp_q.push_back(8'hC3);
    i2c_start();
    write_byte(8'h89, a2);
    checks++; if ({a0, a1, a2} !== 3'b000 || n_load - l0 != 1) begin failures++; $display("FAIL rs_acks got %b%b%b loads=%0d exp 000/1", a0, a1, a2, n_load - l0); end
    do_read("rs", 2);
    i2c_stop();
  endtask

  task automatic test_overrun;
    logic a;
    meas_data = 48'h0123_4567_89AB;
    foreach (meas_data[i]) if (i % 8 == 7) exp_q.push_back(meas_data[i -: 8]);
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    i2c_start(); write_byte(8'h89, a);
    do_read("ovr", 8);
    i2c_stop();
  endtask

  task automatic test_reset_mid_read;
    logic a, s; int p0, w;
    meas_data = 48'h6666_93_8000_A2;
    i2c_start(); write_byte(8'h89, a);
    w = 0;
    while (sda_pull_low !== 1'b1 && w < 40) begin wclk(1); w++; end
    checks++; if (sda_pull_low !== 1'b1) begin failures++; $display("FAIL rst_mid_drive got sda=%b exp=1 (timeout)", sda_pull_low); end
    rst_n = 0; #1;
    checks++; if (sda_pull_low !== 1'b0 || state_out !== 3'd0 || busy !== 1'b0) begin failures++; $display("FAIL rst_mid_async got sda=%b st=%0d busy=%b exp 0/0/0", sda_pull_low, state_out, busy); end
    wclk(3); rst_n = 1; wclk(5);
    p0 = n_pull;
    for (int i = 0; i < 9; i++) put_bit(1'b1, s);
    checks++; if (n_pull != p0 || state_out !== 3'd0) begin failures++; $display("FAIL rst_mid_ignore got pulls=%0d st=%0d exp 0/0", n_pull - p0, state_out); end
    i2c_stop();
  endtask

  task automatic test_back_to_back;
    logic a0, a1; logic [7:0] g;
    i2c_start(); write_byte(8'h88, a0); write_byte(8'h12, a1); i2c_stop();
    g = got_cmd.size() ? got_cmd.pop_front() : 8'hxx;
    checks++; if ({a0, a1} !== 2'b00 || g !== 8'h12) begin failures++; $display("FAIL b2b got acks=%b%b cmd=%h exp 00/12", a0, a1, g); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_addr_mismatch();
    test_read();
    test_repeated_start();
    test_overrun();
    test_reset_mid_read();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
